dm_rr_mem_arbiter: RTL and testbench

//  Parametrised data-memory front end letting NCORES cores share one true dual-port,

---
 rtl/dm_rr_mem_arbiter_if.sv | 32 +++
 rtl/dm_rr_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dm_rr_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_rr_mem_arbiter_if.sv
// Core-side bus of the shared data-memory arbiter.
// Handshake: a core raises req (with we/addr/wdata) and holds all four stable
// until it sees gnt high in a cycle; that cycle is the cycle its access is
// issued to the RAM. There is no ready/backpressure on the return path: a read
// returns exactly one cycle after gnt as rvalid[i] with rdata[i].
interface dm_rr_mem_arbiter_if #(
    parameter int NCORES = 4,
    parameter int AW     = 9,
    parameter int DW     = 16
) ();
    logic [NCORES-1:0]    req;
    logic [NCORES-1:0]    we;
    logic [NCORES*AW-1:0] addr;
    logic [NCORES*DW-1:0] wdata;
    logic [NCORES-1:0]    gnt;
    logic [NCORES-1:0]    rvalid;
    logic [NCORES*DW-1:0] rdata;
    logic [NCORES-1:0]    oob_err;
    logic [15:0]          conflict_cnt;

    // Cores side
    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, oob_err, conflict_cnt
    );

    // Arbiter side
    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, oob_err, conflict_cnt
    );
endinterface

// File: rtl/dm_rr_mem_arbiter.sv
// Round-robin front end letting NCORES cores share one true dual-port RAM.
// Up to two accesses per cycle (port A, port B); same-address hazards between
// the two candidates defer the second one instead of dropping it.
module dm_rr_mem_arbiter #(
    parameter int NCORES = 4,
    parameter int AW     = 9,
    parameter int DW     = 16,
    parameter int MEM_AW = 8,
    localparam int PW    = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    dm_rr_mem_arbiter_if.slave bus,
    output logic [MEM_AW-1:0] ram_addr_a,
    output logic              ram_we_a,
    output logic [DW-1:0]     ram_wdata_a,
    input  logic [DW-1:0]     ram_q_a,
    output logic [MEM_AW-1:0] ram_addr_b,
    output logic              ram_we_b,
    output logic [DW-1:0]     ram_wdata_b,
    input  logic [DW-1:0]     ram_q_b,
    output logic [PW-1:0]     o_dbg_rr_ptr
);

    logic [PW-1:0]     r_rr_ptr;
    logic [15:0]       r_conflict_cnt;
    logic [NCORES-1:0] r_oob_err;
    // Per-port read tags: valid, owning core, out-of-range flag
    logic              r_tv_a, r_tv_b;
    logic [PW-1:0]     r_ti_a, r_ti_b;
    logic              r_to_a, r_to_b;

    logic [AW-1:0]     w_addr [NCORES];
    logic [DW-1:0]     w_wdat [NCORES];
    logic [NCORES-1:0] w_oob;
    logic              w_found_a, w_found_b;
    logic [PW-1:0]     w_idx_a, w_idx_b;
    logic              w_defer;
    logic              w_gnt_a, w_gnt_b;
    logic [PW-1:0]     w_ptr_next;
    logic [NCORES-1:0] w_gnt;
    int                w_c;

    // Unpack per-core address/data and flag out-of-range addresses
    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            w_addr[i] = bus.addr[i*AW +: AW];
            w_wdat[i] = bus.wdata[i*DW +: DW];
            w_oob[i]  = |bus.addr[i*AW+MEM_AW +: AW-MEM_AW];
        end
    end

    // Round-robin scan from r_rr_ptr: first requester is cand A, next is cand B
    always_comb begin
        w_found_a = 1'b0;
        w_found_b = 1'b0;
        w_idx_a   = '0;
        w_idx_b   = '0;
        w_c       = 0;
        for (int k = 0; k < NCORES; k++) begin
            w_c = int'(r_rr_ptr) + k;
            if (w_c >= NCORES) w_c = w_c - NCORES;
            if (bus.req[w_c]) begin
                if (!w_found_a) begin
                    w_found_a = 1'b1;
                    w_idx_a   = PW'(w_c);
                end else if (!w_found_b) begin
                    w_found_b = 1'b1;
                    w_idx_b   = PW'(w_c);
                end
            end
        end
    end

    // Hazard check and grant generation; reset blocks all grants
    always_comb begin
        w_defer = w_found_b &&
                  (w_addr[w_idx_a][MEM_AW-1:0] == w_addr[w_idx_b][MEM_AW-1:0]) &&
                  (bus.we[w_idx_a] || bus.we[w_idx_b]);
        w_gnt_a = w_found_a && !rst;
        w_gnt_b = w_found_b && !w_defer && !rst;
        w_gnt   = '0;
        if (w_gnt_a) w_gnt[w_idx_a] = 1'b1;
        if (w_gnt_b) w_gnt[w_idx_b] = 1'b1;
        bus.gnt = w_gnt;
    end

    // RAM port drive; idle ports are all-zero, out-of-range writes are suppressed
    always_comb begin
        ram_addr_a  = '0;
        ram_we_a    = 1'b0;
        ram_wdata_a = '0;
        ram_addr_b  = '0;
        ram_we_b    = 1'b0;
        ram_wdata_b = '0;
        if (w_gnt_a) begin
            ram_addr_a  = w_addr[w_idx_a][MEM_AW-1:0];
            ram_we_a    = bus.we[w_idx_a] && !w_oob[w_idx_a];
            ram_wdata_a = w_wdat[w_idx_a];
        end
        if (w_gnt_b) begin
            ram_addr_b  = w_addr[w_idx_b][MEM_AW-1:0];
            ram_we_b    = bus.we[w_idx_b] && !w_oob[w_idx_b];
            ram_wdata_b = w_wdat[w_idx_b];
        end
    end

    // Next pointer: one past the last granted core, held when nothing granted
    always_comb begin
        w_ptr_next = r_rr_ptr;
        if (w_gnt_b)
            w_ptr_next = (int'(w_idx_b) == NCORES - 1) ? '0 : w_idx_b + 1'b1;
        else if (w_gnt_a)
            w_ptr_next = (int'(w_idx_a) == NCORES - 1) ? '0 : w_idx_a + 1'b1;
    end

    // Pointer, hazard counter, sticky out-of-range flags and read tags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr       <= '0;
            r_conflict_cnt <= '0;
            r_oob_err      <= '0;
            r_tv_a         <= 1'b0;
            r_tv_b         <= 1'b0;
            r_ti_a         <= '0;
            r_ti_b         <= '0;
            r_to_a         <= 1'b0;
            r_to_b         <= 1'b0;
        end else begin
            r_rr_ptr <= w_ptr_next;
            if (w_found_b && w_defer && r_conflict_cnt != 16'hFFFF)
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            r_oob_err <= r_oob_err | (w_gnt & w_oob);
            r_tv_a    <= w_gnt_a && !bus.we[w_idx_a];
            r_ti_a    <= w_idx_a;
            r_to_a    <= w_oob[w_idx_a];
            r_tv_b    <= w_gnt_b && !bus.we[w_idx_b];
            r_ti_b    <= w_idx_b;
            r_to_b    <= w_oob[w_idx_b];
        end
    end

    // Steer RAM read data back to the owning core one cycle after the grant
    always_comb begin
        bus.rvalid = '0;
        bus.rdata  = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (r_tv_a && int'(r_ti_a) == i) begin
                bus.rvalid[i]         = 1'b1;
                bus.rdata[i*DW +: DW] = r_to_a ? '0 : ram_q_a;
            end
            if (r_tv_b && int'(r_ti_b) == i) begin
                bus.rvalid[i]         = 1'b1;
                bus.rdata[i*DW +: DW] = r_to_b ? '0 : ram_q_b;
            end
        end
    end

    assign bus.oob_err      = r_oob_err;
    assign bus.conflict_cnt = r_conflict_cnt;
    assign o_dbg_rr_ptr     = r_rr_ptr;

endmodule

// File: tb/tb_dm_rr_mem_arbiter.sv
// Bench for dm_rr_mem_arbiter: table vectors, directed corner sequences and a
// randomized phase checked against a queue-based reference model.
module tb_dm_rr_mem_arbiter;
    localparam int NC = 4;
    localparam int AW = 9;
    localparam int DW = 16;
    localparam int MA = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dm_rr_mem_arbiter_if #(.NCORES(NC), .AW(AW), .DW(DW)) bus ();

    logic [MA-1:0] ram_addr_a, ram_addr_b;
    logic          ram_we_a, ram_we_b;
    logic [DW-1:0] ram_wdata_a, ram_wdata_b, ram_q_a, ram_q_b;
    logic [1:0]    dbg_ptr;

    dm_rr_mem_arbiter #(.NCORES(NC), .AW(AW), .DW(DW), .MEM_AW(MA)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ram_addr_a(ram_addr_a), .ram_we_a(ram_we_a), .ram_wdata_a(ram_wdata_a), .ram_q_a(ram_q_a),
        .ram_addr_b(ram_addr_b), .ram_we_b(ram_we_b), .ram_wdata_b(ram_wdata_b), .ram_q_b(ram_q_b),
        .o_dbg_rr_ptr(dbg_ptr)
    );

    // Dual-port RAM with registered q, plus a bench-side preload port
    logic [DW-1:0] ram_mem [256];
    logic          pre_we = 1'b0;
    logic [MA-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    always @(posedge clk) begin
        if (pre_we) ram_mem[pre_addr] <= pre_data;
        if (ram_we_a) ram_mem[ram_addr_a] <= ram_wdata_a;
        if (ram_we_b) ram_mem[ram_addr_b] <= ram_wdata_b;
        ram_q_a <= ram_mem[ram_addr_a];
        ram_q_b <= ram_mem[ram_addr_b];
    end

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_core(input int c, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[c]            = r;
        bus.we[c]             = w;
        bus.addr[c*AW +: AW]  = a;
        bus.wdata[c*DW +: DW] = d;
    endtask

    task automatic clear_inputs();
        bus.req   = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic preload(input logic [MA-1:0] a, input logic [DW-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    typedef struct packed {
        logic [3:0]    req;
        logic [3:0]    we;
        logic [4*AW-1:0] addrs;   // core i at [i*AW +: AW]
        logic [3:0]    exp_gnt;
        logic [15:0]   exp_conf;
        logic [1:0]    exp_ptr;
    } vec_t;

    vec_t vecs [8];

    // model state for the random phase
    logic [DW-1:0] shadow [256];
    int            order [$];
    int            mptr, last, a_i, b_i;
    logic [3:0]    eg, exp_rv, exp_oob;
    logic [15:0]   exp_cnt;
    logic          hz, oob;
    logic [DW-1:0] e;
    int            gcount [NC];

    initial begin
        // Every vector starts from reset, so rr_ptr=0 and conflict_cnt=0
        vecs[0] = '{req:4'b0101, we:4'b0000, addrs:{9'h000, 9'h020, 9'h000, 9'h010}, exp_gnt:4'b0101, exp_conf:16'd0, exp_ptr:2'd3};
        vecs[1] = '{req:4'b1111, we:4'b0000, addrs:{9'h004, 9'h003, 9'h002, 9'h001}, exp_gnt:4'b0011, exp_conf:16'd0, exp_ptr:2'd2};
        vecs[2] = '{req:4'b1000, we:4'b1000, addrs:{9'h011, 9'h000, 9'h000, 9'h000}, exp_gnt:4'b1000, exp_conf:16'd0, exp_ptr:2'd0};
        vecs[3] = '{req:4'b0000, we:4'b0000, addrs:{9'h000, 9'h000, 9'h000, 9'h000}, exp_gnt:4'b0000, exp_conf:16'd0, exp_ptr:2'd0};
        vecs[4] = '{req:4'b0011, we:4'b0001, addrs:{9'h000, 9'h000, 9'h040, 9'h040}, exp_gnt:4'b0001, exp_conf:16'd1, exp_ptr:2'd1};
        vecs[5] = '{req:4'b0111, we:4'b0000, addrs:{9'h000, 9'h044, 9'h040, 9'h040}, exp_gnt:4'b0011, exp_conf:16'd0, exp_ptr:2'd2};
        vecs[6] = '{req:4'b1110, we:4'b0110, addrs:{9'h060, 9'h050, 9'h150, 9'h000}, exp_gnt:4'b0010, exp_conf:16'd1, exp_ptr:2'd2};
        vecs[7] = '{req:4'b1100, we:4'b0000, addrs:{9'h071, 9'h070, 9'h000, 9'h000}, exp_gnt:4'b1100, exp_conf:16'd0, exp_ptr:2'd0};

        clear_inputs();
        for (int i = 0; i < 256; i++) preload(8'(i), 16'(i * 7) ^ 16'h3C00);

        // Reset with every core requesting
        rst = 1'b1;
        bus.req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_gnt", bus.gnt, 0);
            chk("rst_we", {ram_we_a, ram_we_b}, 0);
            chk("rst_rvalid", bus.rvalid, 0);
            chk("rst_conflict", bus.conflict_cnt, 0);
        end
        chk("rst_oob", bus.oob_err, 0);
        chk("rst_ptr", dbg_ptr, 0);

        // Table vectors
        for (int v = 0; v < 8; v++) begin
            do_reset();
            for (int c = 0; c < NC; c++)
                set_core(c, vecs[v].req[c], vecs[v].we[c], vecs[v].addrs[c*AW +: AW], 16'(v * 16 + c));
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", v), bus.gnt, vecs[v].exp_gnt);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_conf", v), bus.conflict_cnt, vecs[v].exp_conf);
            chk($sformatf("vec%0d_ptr", v), dbg_ptr, vecs[v].exp_ptr);
            clear_inputs();
        end

        // Dual read returns data to both cores one cycle later
        do_reset();
        preload(8'h10, 16'hAAAA);
        preload(8'h20, 16'h5555);
        set_core(0, 1'b1, 1'b0, 9'h010, 16'h0);
        set_core(2, 1'b1, 1'b0, 9'h020, 16'h0);
        @(negedge clk);
        chk("dual_gnt", bus.gnt, 4'b0101);
        @(posedge clk);
        #1 clear_inputs();
        @(negedge clk);
        chk("dual_rvalid", bus.rvalid, 4'b0101);
        chk("dual_rdata0", bus.rdata[0 +: DW], 16'hAAAA);
        chk("dual_rdata2", bus.rdata[2*DW +: DW], 16'h5555);
        chk("dual_ptr", dbg_ptr, 3);

        // Write hazard from rr_ptr=1: core1 wins, core3 follows
        do_reset();
        set_core(0, 1'b1, 1'b0, 9'h000, 16'h0);
        @(posedge clk);
        #1;
        chk("haz_ptr1", dbg_ptr, 1);
        set_core(0, 1'b0, 1'b0, 9'h000, 16'h0);
        set_core(1, 1'b1, 1'b1, 9'h040, 16'h1111);
        set_core(3, 1'b1, 1'b1, 9'h040, 16'h2222);
        @(negedge clk);
        chk("haz_gnt0", bus.gnt, 4'b0010);
        @(posedge clk);
        #1;
        chk("haz_conf", bus.conflict_cnt, 1);
        set_core(1, 1'b0, 1'b0, 9'h000, 16'h0);
        @(negedge clk);
        chk("haz_gnt1", bus.gnt, 4'b1000);
        @(posedge clk);
        #1 clear_inputs();
        chk("haz_ram40", ram_mem[8'h40], 16'h2222);
        chk("haz_conf_hold", bus.conflict_cnt, 1);

        // Fairness: four continuous readers, pairs alternate
        do_reset();
        for (int c = 0; c < NC; c++) begin
            set_core(c, 1'b1, 1'b0, 9'(c * 4 + 1), 16'h0);
            gcount[c] = 0;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("fair_pair%0d", k), bus.gnt, (k % 2 == 0) ? 4'b0011 : 4'b1100);
            for (int c = 0; c < NC; c++) if (bus.gnt[c]) gcount[c]++;
            @(posedge clk);
            #1;
        end
        clear_inputs();
        for (int c = 0; c < NC; c++) chk($sformatf("fair_count%0d", c), gcount[c], 4);

        // Out-of-range write then read on core1
        do_reset();
        preload(8'hF0, 16'h1234);
        set_core(1, 1'b1, 1'b1, 9'h1F0, 16'hBEEF);
        @(negedge clk);
        chk("oob_wr_gnt", bus.gnt, 4'b0010);
        chk("oob_wr_we", ram_we_a, 0);
        @(posedge clk);
        #1 set_core(1, 1'b1, 1'b0, 9'h100, 16'h0);
        @(negedge clk);
        chk("oob_rd_gnt", bus.gnt, 4'b0010);
        @(posedge clk);
        #1 clear_inputs();
        @(negedge clk);
        chk("oob_rvalid", bus.rvalid, 4'b0010);
        chk("oob_rdata", bus.rdata[DW +: DW], 0);
        chk("oob_err", bus.oob_err, 4'b0010);
        repeat (2) @(posedge clk);
        #1;
        chk("oob_sticky", bus.oob_err, 4'b0010);
        chk("oob_ram_untouched", ram_mem[8'hF0], 16'h1234);

        // Reset right after a read grant kills the return
        do_reset();
        set_core(2, 1'b1, 1'b0, 9'h030, 16'h0);
        @(negedge clk);
        chk("rstmid_gnt", bus.gnt, 4'b0100);
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        chk("rstmid_rvalid", bus.rvalid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_rvalid2", bus.rvalid, 0);
        chk("rstmid_ptr", dbg_ptr, 0);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 256; i++) shadow[i] = ram_mem[i];
        exp_q.delete();
        mptr = 0; exp_rv = '0; exp_oob = '0; exp_cnt = '0;
        for (int c = 0; c < NC; c++)
            set_core(c, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     {($urandom_range(0, 7) == 0), 8'($urandom_range(0, 7))}, 16'($urandom));
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            chk("rnd_rvalid", bus.rvalid, exp_rv);
            for (int c = 0; c < NC; c++) begin
                if (exp_rv[c] && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("rnd_rdata%0d", c), bus.rdata[c*DW +: DW], e);
                end
            end
            // requesters in priority order starting at the model pointer
            order.delete();
            for (int k = 0; k < NC; k++)
                if (bus.req[(mptr + k) % NC]) order.push_back((mptr + k) % NC);
            eg = '0; hz = 1'b0; last = -1;
            if (order.size() >= 1) begin
                a_i = order[0];
                eg[a_i] = 1'b1;
                last = a_i;
            end
            if (order.size() >= 2) begin
                b_i = order[1];
                if (bus.addr[a_i*AW +: MA] == bus.addr[b_i*AW +: MA] && (bus.we[a_i] || bus.we[b_i]))
                    hz = 1'b1;
                else begin
                    eg[b_i] = 1'b1;
                    last = b_i;
                end
            end
            chk("rnd_gnt", bus.gnt, eg);
            if (hz && exp_cnt != 16'hFFFF) exp_cnt++;
            exp_rv = '0;
            for (int c = 0; c < NC; c++) begin
                if (eg[c]) begin
                    oob = bus.addr[c*AW + MA];
                    if (oob) exp_oob[c] = 1'b1;
                    if (!bus.we[c]) begin
                        exp_rv[c] = 1'b1;
                        exp_q.push_back(oob ? 16'h0 : shadow[bus.addr[c*AW +: MA]]);
                    end
                end
            end
            for (int c = 0; c < NC; c++)
                if (eg[c] && bus.we[c] && !bus.addr[c*AW + MA])
                    shadow[bus.addr[c*AW +: MA]] = bus.wdata[c*DW +: DW];
            if (last >= 0) mptr = (last + 1) % NC;
            @(posedge clk);
            #1;
            chk("rnd_conf", bus.conflict_cnt, exp_cnt);
            chk("rnd_oob", bus.oob_err, exp_oob);
            chk("rnd_ptr", dbg_ptr, mptr);
            for (int c = 0; c < NC; c++) begin
                if (eg[c] || !bus.req[c]) begin
                    if ($urandom_range(0, 3) != 0)
                        set_core(c, 1'b1, 1'($urandom_range(0, 1)),
                                 {($urandom_range(0, 7) == 0), 8'($urandom_range(0, 7))}, 16'($urandom));
                    else
                        set_core(c, 1'b0, 1'b0, 9'h000, 16'h0);
                end
            end
        end
        clear_inputs();
        @(negedge clk);
        chk("rnd_final_rvalid", bus.rvalid, exp_rv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
